// File: rtl/soc_irq_timer_pkg.sv
// soc_irq_timer_pkg: register map, reset values and byte-lane helpers for soc_irq_timer
package soc_irq_timer_pkg;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] OFF_PRESCALE    = 8'h10;
    localparam logic [7:0] OFF_PENDING     = 8'h14;
    localparam logic [7:0] OFF_ENABLE      = 8'h18;
    localparam logic [7:0] OFF_EDGE        = 8'h1C;
    localparam logic [63:0] MTIMECMP_RST = '1;
    localparam logic [15:0] PRESCALE_RST = '0;
    typedef enum logic [2:0] {
        REG_MTIME_LO    = OFF_MTIME_LO[4:2],
        REG_MTIME_HI    = OFF_MTIME_HI[4:2],
        REG_MTIMECMP_LO = OFF_MTIMECMP_LO[4:2],
        REG_MTIMECMP_HI = OFF_MTIMECMP_HI[4:2],
        REG_PRESCALE    = OFF_PRESCALE[4:2],
        REG_PENDING     = OFF_PENDING[4:2],
        REG_ENABLE      = OFF_ENABLE[4:2],
        REG_EDGE        = OFF_EDGE[4:2]
    } reg_addr_e;
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [31:0] mask);
        return (old & ~mask) | (wdata & mask);
    endfunction
endpackage

// File: rtl/soc_mtime_counter.sv
// soc_mtime_counter: prescaled 64-bit mtime, mtimecmp storage and registered timer compare
module soc_mtime_counter
    import soc_irq_timer_pkg::*;
#(
    parameter logic [63:0] MTIME_RST = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_mtime_lo,
    input  logic        wr_mtime_hi,
    input  logic        wr_cmp_lo,
    input  logic        wr_cmp_hi,
    input  logic        wr_prescale,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic [15:0] prescale,
    output logic        timer_irq
);
    logic [15:0] cnt;
    logic        tick;
    assign tick = cnt == prescale;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            prescale  <= PRESCALE_RST;
            mtime     <= MTIME_RST;
            mtimecmp  <= MTIMECMP_RST;
            timer_irq <= 1'b0;
        end else begin
            cnt <= (wr_prescale || tick) ? '0 : cnt + 16'd1;
            if (wr_prescale) prescale <= (prescale & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
            // a software write to either half suppresses that cycle's increment
            if (wr_mtime_lo) mtime[31:0] <= lane_merge(mtime[31:0], wdata, wmask);
            else if (wr_mtime_hi) mtime[63:32] <= lane_merge(mtime[63:32], wdata, wmask);
            else if (tick) mtime <= mtime + 64'd1;
            if (wr_cmp_lo) mtimecmp[31:0] <= lane_merge(mtimecmp[31:0], wdata, wmask);
            if (wr_cmp_hi) mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], wdata, wmask);
            timer_irq <= mtime >= mtimecmp;
        end
    end
endmodule

// File: rtl/soc_irq_timer.sv
// soc_irq_timer: Wishbone machine timer plus external interrupt aggregator
module soc_irq_timer
    import soc_irq_timer_pkg::*;
#(
    parameter int unsigned NUM_IRQ   = 4,
    parameter logic [63:0] MTIME_RST = 64'h0
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic               timer_irq_o,
    output logic               ext_irq_o
);
    logic               req, wr;
    logic [31:0]        wmask, rdata, hi_shadow;
    logic [63:0]        mtime, mtimecmp;
    logic [15:0]        prescale;
    logic [NUM_IRQ-1:0] src_q, pending, enable, edge_en, w1c, wd, wm;
    logic               unused_adr;
    reg_addr_e          addr;
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
    assign addr       = reg_addr_e'(wb_adr_i[4:2]);
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr         = req & wb_we_i;
    assign wmask      = byte_mask(wb_sel_i);
    assign wd         = wb_dat_i[NUM_IRQ-1:0];
    assign wm         = wmask[NUM_IRQ-1:0];
    assign w1c        = (wr && addr == REG_PENDING) ? wd & wm : '0;
    assign wb_err_o   = 1'b0;

    soc_mtime_counter #(.MTIME_RST(MTIME_RST)) u_mtime (
        .clk         (wb_clk),
        .rst_n       (wb_rst_n),
        .wr_mtime_lo (wr && addr == REG_MTIME_LO),
        .wr_mtime_hi (wr && addr == REG_MTIME_HI),
        .wr_cmp_lo   (wr && addr == REG_MTIMECMP_LO),
        .wr_cmp_hi   (wr && addr == REG_MTIMECMP_HI),
        .wr_prescale (wr && addr == REG_PRESCALE),
        .wdata       (wb_dat_i),
        .wmask       (wmask),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .prescale    (prescale),
        .timer_irq   (timer_irq_o)
    );

    always_comb begin
        rdata = '0;
        case (addr)
            REG_MTIME_LO:    rdata = mtime[31:0];
            REG_MTIME_HI:    rdata = hi_shadow;
            REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
            REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
            REG_PRESCALE:    rdata = {16'h0, prescale};
            REG_PENDING:     rdata = 32'(pending);
            REG_ENABLE:      rdata = 32'(enable);
            default:         rdata = 32'(edge_en);
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            hi_shadow <= '0;
            src_q     <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_en   <= '0;
            ext_irq_o <= 1'b0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= req ? rdata : '0;
            // reading the low word freezes the high word so a LO/HI pair is coherent
            if (req && !wb_we_i && addr == REG_MTIME_LO) hi_shadow <= mtime[63:32];
            if (wr && addr == REG_ENABLE) enable <= (enable & ~wm) | (wd & wm);
            if (wr && addr == REG_EDGE) edge_en <= (edge_en & ~wm) | (wd & wm);
            src_q     <= irq_src_i;
            pending   <= (edge_en & ((irq_src_i & ~src_q) | (pending & ~w1c))) | (~edge_en & irq_src_i);
            ext_irq_o <= |(pending & enable);
        end
    end
endmodule

// File: tb/tb_soc_irq_timer.sv
// tb_soc_irq_timer: randomized self-checking bench for soc_irq_timer
module tb_soc_irq_timer;
    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [3:0]  irq_src_i = '0;
    logic        timer_irq_o;
    logic        ext_irq_o;

    int checks = 0;
    int errs = 0;
    longint unsigned base;
    int e0, ew, ps;

    soc_irq_timer #(.NUM_IRQ(4), .MTIME_RST(64'h0)) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .irq_src_i   (irq_src_i),
        .timer_irq_o (timer_irq_o),
        .ext_irq_o   (ext_irq_o)
    );

    always #5 wb_clk = ~wb_clk;

    // index of the most recent rising edge, valid when called at a falling edge
    function automatic int now_edge();
        return int'($time / 10) - 1;
    endfunction

    // expected mtime after edge k: value written at edge ew plus the prescaler ticks since then
    function automatic longint unsigned mt(input int k);
        return base + 64'((k - e0) / (ps + 1) - (ew - e0) / (ps + 1));
    endfunction

    task automatic bus(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r, output int e);
        @(negedge wb_clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {24'h0, a};
        wb_dat_i = d;
        wb_sel_i = s;
        @(negedge wb_clk);
        e = now_edge();
        r = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output int e);
        logic [31:0] r;
        bus(1'b1, a, d, s, r, e);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output int e);
        bus(1'b0, a, 32'h0, 4'hF, d, e);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int e;
        repeat (3) @(negedge wb_clk);
        checks++;
        if ({wb_ack_o, wb_err_o, timer_irq_o, ext_irq_o, wb_dat_o} !== 36'h0) begin
            errs++;
            $display("FAIL reset_outputs: got %h expected 0", {wb_ack_o, wb_err_o, timer_irq_o, ext_irq_o, wb_dat_o});
        end
        wb_rst_n = 1'b1;
        rd(8'h08, d, e);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errs++; $display("FAIL reset_cmp_lo: got %h expected ffffffff", d); end
        rd(8'h0C, d, e);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errs++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", d); end
        for (int a = 8'h10; a <= 8'h1C; a += 4) begin
            rd(8'(a), d, e);
            checks++;
            if (d !== 32'h0) begin errs++; $display("FAIL reset_reg_%0h: got %h expected 0", a, d); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge wb_clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 32'h08;
        for (int k = 1; k <= 8; k++) begin
            @(negedge wb_clk);
            checks++;
            if (wb_ack_o !== 1'(k % 2)) begin
                errs++;
                $display("FAIL b2b_ack_%0d: got %b expected %b", k, wb_ack_o, 1'(k % 2));
            end
            if (k % 2 == 1) begin
                checks++;
                if (wb_dat_o !== 32'hFFFF_FFFF) begin errs++; $display("FAIL b2b_data_%0d: got %h expected ffffffff", k, wb_dat_o); end
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        longint unsigned m;
        int e;
        for (int i = 0; i < 5; i++) begin
            ps = (i == 0) ? 3 : int'($urandom_range(1, 6));
            wr(8'h10, 32'(ps), 4'hF, e0);
            wr(8'h04, 32'h0, 4'hF, e);
            base = 64'($urandom_range(0, 1000));
            wr(8'h00, base[31:0], 4'hF, ew);
            repeat ($urandom_range(3, 30)) @(negedge wb_clk);
            rd(8'h00, d, e);
            m = mt(e - 1);
            checks++;
            if (d !== m[31:0]) begin errs++; $display("FAIL prescale_mtime ps=%0d: got %0d expected %0d", ps, d, m[31:0]); end
            rd(8'h04, d, e);
            checks++;
            if (d !== m[63:32]) begin errs++; $display("FAIL prescale_hi: got %h expected %h", d, m[63:32]); end
        end
    endtask

    task automatic test_timer();
        longint unsigned m;
        int e, ec;
        ps = 3;
        wr(8'h10, 32'd3, 4'hF, e0);
        wr(8'h04, 32'h0, 4'hF, e);
        base = 64'h0;
        wr(8'h00, 32'h0, 4'hF, ew);
        wr(8'h0C, 32'h0, 4'hF, e);
        wr(8'h08, 32'd10, 4'hF, ec);
        for (int i = 0; i < 80; i++) begin
            @(negedge wb_clk);
            e = now_edge();
            m = mt(e - 1);
            checks++;
            if (timer_irq_o !== (m >= 64'd10)) begin
                errs++;
                $display("FAIL timer_cmp mtime=%0d: got %b expected %b", m, timer_irq_o, m >= 64'd10);
            end
            if (m >= 64'd12) break;
        end
        checks++;
        if (timer_irq_o !== 1'b1) begin errs++; $display("FAIL timer_rise: got %b expected 1", timer_irq_o); end
        wr(8'h0C, 32'h1, 4'hF, e);
        checks++;
        if (timer_irq_o !== 1'b1) begin errs++; $display("FAIL timer_hold: got %b expected 1", timer_irq_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk);
            checks++;
            if (timer_irq_o !== 1'b0) begin errs++; $display("FAIL timer_fall_%0d: got %b expected 0", i, timer_irq_o); end
        end
    endtask

    task automatic test_atomic_read();
        logic [31:0] d;
        longint unsigned m;
        int e;
        ps = 0;
        wr(8'h10, 32'h0, 4'hF, e0);
        wr(8'h04, 32'h0, 4'hF, e);
        base = 64'hFFFF_FFFF;
        wr(8'h00, 32'hFFFF_FFFF, 4'hF, ew);
        rd(8'h00, d, e);
        m = mt(e - 1);
        checks++;
        if (d !== m[31:0]) begin errs++; $display("FAIL atomic_lo: got %h expected %h", d, m[31:0]); end
        wr(8'h04, 32'h5, 4'hF, e);
        rd(8'h04, d, e);
        checks++;
        if (d !== m[63:32] || d !== 32'h1) begin errs++; $display("FAIL atomic_shadow: got %h expected %h", d, m[63:32]); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        int e;
        wr(8'h1C, 32'h1, 4'hF, e);
        wr(8'h18, 32'h3, 4'hF, e);
        wr(8'h14, 32'hF, 4'hF, e);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 4)) @(negedge wb_clk);
            irq_src_i[0] = 1'b1;
            @(negedge wb_clk);
            irq_src_i[0] = 1'b0;
            checks++;
            if (ext_irq_o !== 1'b0) begin errs++; $display("FAIL edge_ext_early: got %b expected 0", ext_irq_o); end
            @(negedge wb_clk);
            checks++;
            if (ext_irq_o !== 1'b1) begin errs++; $display("FAIL edge_ext_rise: got %b expected 1", ext_irq_o); end
            rd(8'h14, d, e);
            checks++;
            if (d !== 32'h1) begin errs++; $display("FAIL edge_pending: got %h expected 1", d); end
            wr(8'h14, 32'h1, 4'hF, e);
            @(negedge wb_clk);
            checks++;
            if (ext_irq_o !== 1'b0) begin errs++; $display("FAIL edge_w1c_ext: got %b expected 0", ext_irq_o); end
            rd(8'h14, d, e);
            checks++;
            if (d !== 32'h0) begin errs++; $display("FAIL edge_w1c_pending: got %h expected 0", d); end
        end
        @(negedge wb_clk);
        irq_src_i[0] = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h14;
        wb_dat_i = 32'h1;
        wb_sel_i = 4'hF;
        @(negedge wb_clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        rd(8'h14, d, e);
        checks++;
        if (d !== 32'h1) begin errs++; $display("FAIL edge_collision: got %h expected 1", d); end
        irq_src_i[0] = 1'b0;
        wr(8'h14, 32'h1, 4'hF, e);
    endtask

    task automatic test_level_irq();
        logic [31:0] d;
        int e;
        wr(8'h1C, 32'h1, 4'hF, e);
        wr(8'h18, 32'h3, 4'hF, e);
        @(negedge wb_clk);
        irq_src_i[1] = 1'b1;
        repeat (2) @(negedge wb_clk);
        wr(8'h14, 32'h2, 4'hF, e);
        rd(8'h14, d, e);
        checks++;
        if (d !== 32'h2) begin errs++; $display("FAIL level_w1c: got %h expected 2", d); end
        checks++;
        if (ext_irq_o !== 1'b1) begin errs++; $display("FAIL level_ext: got %b expected 1", ext_irq_o); end
        @(negedge wb_clk);
        irq_src_i[1] = 1'b0;
        @(negedge wb_clk);
        checks++;
        if (ext_irq_o !== 1'b1) begin errs++; $display("FAIL level_ext_hold: got %b expected 1", ext_irq_o); end
        @(negedge wb_clk);
        checks++;
        if (ext_irq_o !== 1'b0) begin errs++; $display("FAIL level_ext_fall: got %b expected 0", ext_irq_o); end
        rd(8'h14, d, e);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL level_release: got %h expected 0", d); end
    endtask

    // random source activity: level bits mirror the source, edge bits latch any rising edge seen
    task automatic test_random_irq();
        logic [31:0] d;
        logic [3:0] edg, en, s, prev, seen, pend, pend_prev;
        int e, idx;
        edg = 4'($urandom);
        en  = 4'($urandom_range(1, 15));
        irq_src_i = '0;
        wr(8'h1C, 32'(edg), 4'hF, e);
        wr(8'h18, 32'(en), 4'hF, e);
        wr(8'h14, 32'hF, 4'hF, e);
        repeat (2) @(negedge wb_clk);
        s = '0;
        prev = '0;
        seen = '0;
        pend_prev = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk);
            seen = seen | (s & ~prev & edg);
            pend = (edg & seen) | (~edg & s);
            checks++;
            if (ext_irq_o !== |(pend_prev & en)) begin
                errs++;
                $display("FAIL random_ext cycle %0d: got %b expected %b", i, ext_irq_o, |(pend_prev & en));
            end
            pend_prev = pend;
            prev = s;
            if ($urandom_range(0, 2) == 0) begin
                idx = int'($urandom_range(0, 3));
                s[idx] = ~s[idx];
            end
            irq_src_i = s;
        end
        irq_src_i = '0;
        repeat (3) @(negedge wb_clk);
        rd(8'h14, d, e);
        checks++;
        if (d !== 32'(seen & edg)) begin errs++; $display("FAIL random_pending: got %h expected %h", d, 32'(seen & edg)); end
        wr(8'h14, 32'hF, 4'hF, e);
    endtask

    task automatic test_byte_lane();
        logic [31:0] d, old, nd, exp;
        logic [3:0] s;
        int e;
        wr(8'h10, 32'hFFFF, 4'hF, e);
        wr(8'h04, 32'h0, 4'hF, e);
        wr(8'h00, 32'h0, 4'hF, e);
        wr(8'h00, 32'h7878_7878, 4'b0010, e);
        rd(8'h00, d, e);
        checks++;
        if (d !== 32'h0000_7800) begin errs++; $display("FAIL lane_spec: got %h expected 00007800", d); end
        for (int i = 0; i < 6; i++) begin
            old = $urandom;
            nd  = $urandom;
            s   = 4'($urandom);
            for (int b = 0; b < 4; b++) exp[8*b +: 8] = s[b] ? nd[8*b +: 8] : old[8*b +: 8];
            wr(8'h00, old, 4'hF, e);
            wr(8'h00, nd, s, e);
            rd(8'h00, d, e);
            checks++;
            if (d !== exp) begin errs++; $display("FAIL lane_mtime sel=%b: got %h expected %h", s, d, exp); end
            wr(8'h18, old, 4'hF, e);
            wr(8'h18, nd, s, e);
            rd(8'h18, d, e);
            checks++;
            if (d !== (exp & 32'hF)) begin errs++; $display("FAIL lane_enable sel=%b: got %h expected %h", s, d, exp & 32'hF); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        longint unsigned m;
        int e;
        @(negedge wb_clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h1C;
        wb_dat_i = 32'hF;
        wb_sel_i = 4'hF;
        @(posedge wb_clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b1) begin errs++; $display("FAIL midrst_ack_before: got %b expected 1", wb_ack_o); end
        wb_rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_ack_o, timer_irq_o, ext_irq_o, wb_dat_o} !== 35'h0) begin
            errs++;
            $display("FAIL midrst_outputs: got %h expected 0", {wb_ack_o, timer_irq_o, ext_irq_o, wb_dat_o});
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        ps = 0;
        base = 64'h0;
        e0 = now_edge();
        ew = e0;
        rd(8'h00, d, e);
        m = mt(e - 1);
        checks++;
        if (d !== m[31:0]) begin errs++; $display("FAIL midrst_mtime: got %0d expected %0d", d, m[31:0]); end
        rd(8'h1C, d, e);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL midrst_edge: got %h expected 0", d); end
        rd(8'h18, d, e);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL midrst_enable: got %h expected 0", d); end
        rd(8'h10, d, e);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL midrst_prescale: got %h expected 0", d); end
        rd(8'h0C, d, e);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errs++; $display("FAIL midrst_cmp_hi: got %h expected ffffffff", d); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_prescale();
        test_timer();
        test_atomic_read();
        test_edge_irq();
        test_level_irq();
        test_random_irq();
        test_byte_lane();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
